fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter: DW, 256, data width of each source port and of the FIFO write port.
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 nrst  input  1  reset; asynchronous, active-low.
REQ-004 s0_data  input  DW  source 0 write data.
REQ-005 s0_valid  input  1  source 0 beat available.
REQ-006 s0_last  input  1  source 0 beat is the final beat of its packet.
REQ-007 s0_ready  output  1  source 0 beat accepted this cycle when high together with s0_valid.
REQ-008 s1_data / s1_valid / s1_last / s1_ready  same directions, widths and meanings as REQ-004..007, for source 1.
REQ-009 fifo_din  output  DW  FIFO write data.
REQ-010 fifo_wr_en  output  1  FIFO write strobe.
REQ-011 fifo_full  input  1  FIFO full.
REQ-012 fifo_rdy  input  1  FIFO initialised and accepting writes.
REQ-013 pkt_cnt0 / pkt_cnt1  output  32  completed-packet counts per source (present only with ARB_PKT_CNT_EN).

Function
REQ-014 The FSM SHALL have four states: WAIT_RDY, IDLE, GNT0 and GNT1.
REQ-015 WAIT_RDY: no grants are issued; the FSM SHALL move to IDLE on the first cycle fifo_rdy=1.
REQ-016 IDLE: if exactly one sx_valid=1, the FSM SHALL go to GNTx; if both are 1, it SHALL go to the source not recorded in last_served; otherwise it stays in IDLE.
REQ-017 sx_ready SHALL equal (state==GNTx) & ~fifo_full & fifo_rdy, combinationally; it SHALL be 0 in every other state.
REQ-018 fifo_wr_en SHALL equal the valid & ready of the granted source; fifo_din SHALL mux the granted source's data; latency is 0 (same-cycle pass-through).
REQ-019 A grant SHALL persist until a beat with sx_last=1 is accepted; no interleaving of packets.
REQ-020 On acceptance of a last beat, last_served SHALL be set to x, and the next state SHALL be:
  - GNT of the other source if its valid=1;
  - otherwise GNTx if sx_valid=1;
  - otherwise IDLE.
  Switching sources SHALL take no bubble cycle.
REQ-021 fifo_full=1 or fifo_rdy=0 in GNTx: sx_ready=0, fifo_wr_en=0, state and grant held; no beat is lost or duplicated.
REQ-022 fifo_rdy falling after WAIT_RDY SHALL only stall per REQ-021; it SHALL NOT return the FSM to WAIT_RDY.
REQ-023 A single-beat packet (valid & last on first beat) SHALL complete in one accepted cycle.
REQ-024 fifo_wr_en SHALL never assert while fifo_full=1.

Reset
REQ-025 When nrst=0, the block SHALL reset to:
  - state=WAIT_RDY and last_served=1 (source 0 wins the first tie);
  - s0_ready=s1_ready=0 and fifo_wr_en=0;
  - fifo_din=0;
  - pkt_cnt0=pkt_cnt1=0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet immediately; after release the FSM SHALL re-enter via WAIT_RDY.

Configuration
REQ-027 Macro ARB_PKT_CNT_EN defined: pkt_cnt0/pkt_cnt1 SHALL exist.
  - Each counter SHALL increment by 1 on acceptance of a last beat from its source.
  - Each counter SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 Macro ARB_PKT_CNT_EN undefined: the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Startup: fifo_rdy=0 for 10 cycles after reset with s0_valid=1 -> fifo_wr_en=0 throughout; first write occurs once fifo_rdy=1 plus 1 cycle (IDLE->GNT0).
REQ-030 Tie: s0 and s1 both present 4-beat packets from IDLE after reset.
  - fifo_din SHALL carry the s0 beats 1..4, then the s1 beats 1..4, back-to-back.
  - fifo_wr_en SHALL stay high for 8 consecutive cycles.
  - pkt_cnt0=pkt_cnt1=1.
REQ-031 Backpressure: fifo_full=1 for 3 cycles during beat 2 of an s1 packet -> no writes during those cycles; beat 2 is written exactly once after full drops; the grant remains s1.
REQ-032 Fairness: s0 and s1 continuously valid with single-beat packets for 100 cycles -> writes alternate s0,s1,...; 50 writes each; pkt_cnt0=pkt_cnt1=50.
REQ-033 Reset mid-packet: nrst pulsed low after beat 2 of a 5-beat s0 packet -> outputs are 0 immediately; state=WAIT_RDY; counters=0.
REQ-034 Counter wrap (ARB_PKT_CNT_EN): force pkt_cnt0=0xFFFFFFFF, complete one s0 packet -> pkt_cnt0=0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Two-source packet arbiter feeding a FIFO write port with same-cycle pass-through.
// Define ARB_PKT_CNT_EN to add the per-source completed-packet counters.
module fifo_wr_arb #(
   parameter int DW = 256
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic [DW-1:0] s0_data,
   input  logic          s0_valid,
   input  logic          s0_last,
   output logic          s0_ready,
   input  logic [DW-1:0] s1_data,
   input  logic          s1_valid,
   input  logic          s1_last,
   output logic          s1_ready,
`ifdef ARB_PKT_CNT_EN
   output logic [31:0]   pkt_cnt0,
   output logic [31:0]   pkt_cnt1,
`endif
   output logic [DW-1:0] fifo_din,
   output logic          fifo_wr_en,
   input  logic          fifo_full,
   input  logic          fifo_rdy
);

   typedef enum logic [1:0] {
      WAIT_RDY = 2'd0,
      IDLE     = 2'd1,
      GNT0     = 2'd2,
      GNT1     = 2'd3
   } state_t;

   state_t state_r;
   state_t next_s;
   logic   last_served_r;
   logic   done0_s;
   logic   done1_s;

   // A packet ends when its last beat is actually accepted, not merely presented
   assign done0_s = s0_valid & s0_ready & s0_last;
   assign done1_s = s1_valid & s1_ready & s1_last;

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r <= WAIT_RDY;
      end else begin
         state_r <= next_s;
      end
   end

   // Remembers which source finished most recently; reset value lets source 0 win the first tie
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         last_served_r <= 1'b1;
      end else if (done0_s) begin
         last_served_r <= 1'b0;
      end else if (done1_s) begin
         last_served_r <= 1'b1;
      end else begin
         last_served_r <= last_served_r;
      end
   end

   // Next-state logic; grants are held until a last beat is accepted
   always_comb begin
      next_s = state_r;
      case (state_r)
         WAIT_RDY: begin
            if (fifo_rdy) next_s = IDLE;
            else          next_s = WAIT_RDY;
         end
         IDLE: begin
            if (s0_valid && s1_valid) next_s = last_served_r ? GNT0 : GNT1;
            else if (s0_valid)        next_s = GNT0;
            else if (s1_valid)        next_s = GNT1;
            else                      next_s = IDLE;
         end
         GNT0: begin
            if (done0_s) begin
               if (s1_valid)      next_s = GNT1;
               else if (s0_valid) next_s = GNT0;
               else               next_s = IDLE;
            end else begin
               next_s = GNT0;
            end
         end
         GNT1: begin
            if (done1_s) begin
               if (s0_valid)      next_s = GNT0;
               else if (s1_valid) next_s = GNT1;
               else               next_s = IDLE;
            end else begin
               next_s = GNT1;
            end
         end
         default: next_s = WAIT_RDY;
      endcase
   end

   // Output logic: zero-latency mux of the granted source onto the FIFO port
   always_comb begin
      s0_ready   = 1'b0;
      s1_ready   = 1'b0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      case (state_r)
         GNT0: begin
            s0_ready   = ~fifo_full & fifo_rdy;
            fifo_wr_en = s0_valid & ~fifo_full & fifo_rdy;
            fifo_din   = s0_data;
         end
         GNT1: begin
            s1_ready   = ~fifo_full & fifo_rdy;
            fifo_wr_en = s1_valid & ~fifo_full & fifo_rdy;
            fifo_din   = s1_data;
         end
         default: begin
            s0_ready   = 1'b0;
            s1_ready   = 1'b0;
            fifo_wr_en = 1'b0;
            fifo_din   = '0;
         end
      endcase
   end

`ifdef ARB_PKT_CNT_EN
   logic [31:0] pkt_cnt0_r;
   logic [31:0] pkt_cnt1_r;

   // Completed-packet counters, wrapping naturally at 32 bits
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pkt_cnt0_r <= 32'd0;
         pkt_cnt1_r <= 32'd0;
      end else begin
         if (done0_s) pkt_cnt0_r <= pkt_cnt0_r + 32'd1;
         else         pkt_cnt0_r <= pkt_cnt0_r;
         if (done1_s) pkt_cnt1_r <= pkt_cnt1_r + 32'd1;
         else         pkt_cnt1_r <= pkt_cnt1_r;
      end
   end

   assign pkt_cnt0 = pkt_cnt0_r;
   assign pkt_cnt1 = pkt_cnt1_r;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed, scoreboard-based bench for fifo_wr_arb; counter checks compile in with ARB_PKT_CNT_EN.
module tb_fifo_wr_arb;

   localparam int DW = 256;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          nrst;
   logic [DW-1:0] s0_data, s1_data;
   logic          s0_valid, s0_last, s0_ready;
   logic          s1_valid, s1_last, s1_ready;
   logic [DW-1:0] fifo_din;
   logic          fifo_wr_en, fifo_full, fifo_rdy;
`ifdef ARB_PKT_CNT_EN
   logic [31:0]   pkt_cnt0, pkt_cnt1;
`endif

   beat_t         src0_q[$];
   beat_t         src1_q[$];
   logic [DW-1:0] exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int w0, w1, run, max_run;
   logic wr_s, rdy0_s, rdy1_s;

   fifo_wr_arb #(.DW(DW)) dut (
      .clk(clk), .nrst(nrst),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
`ifdef ARB_PKT_CNT_EN
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
      .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_rdy(fifo_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int src, input int pkt, input int beat);
      logic [31:0] t;
      t = {src[7:0], pkt[7:0], beat[15:0]};
      return {8{t}};
   endfunction

   // Each source drives the head of its own beat queue
   task automatic drive();
      s0_valid = (src0_q.size() > 0);
      s0_data  = s0_valid ? src0_q[0].data : '0;
      s0_last  = s0_valid ? src0_q[0].last : 1'b0;
      s1_valid = (src1_q.size() > 0);
      s1_data  = s1_valid ? src1_q[0].data : '0;
      s1_last  = s1_valid ? src1_q[0].last : 1'b0;
   endtask

   // Queue a packet on a source; arrival order of calls is the expected write order
   task automatic add_pkt(input int src, input int pkt, input int nbeats);
      beat_t b;
      for (int i = 1; i <= nbeats; i++) begin
         b.data = mk(src, pkt, i);
         b.last = (i == nbeats);
         if (src == 0) src0_q.push_back(b);
         else          src1_q.push_back(b);
         exp_q.push_back(b.data);
      end
   endtask

   // One clock: sample/score mid-cycle, then advance the sources just after the edge
   task automatic tick();
      logic acc0, acc1;
      logic [DW-1:0] exp;
      @(negedge clk);
      acc0   = s0_valid & s0_ready;
      acc1   = s1_valid & s1_ready;
      wr_s   = fifo_wr_en;
      rdy0_s = s0_ready;
      rdy1_s = s1_ready;
      check("wr_while_full", DW'(fifo_wr_en & fifo_full), '0);
      check("wr_en_vs_accept", DW'(fifo_wr_en), DW'(acc0 | acc1));
      if (fifo_wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", fifo_din, '0);
         end else begin
            exp = exp_q.pop_front();
            check("fifo_din", fifo_din, exp);
         end
         if (fifo_din[31:24] == 8'd0) w0++;
         else                         w1++;
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      @(posedge clk);
      #1;
      if (acc0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (acc1 && src1_q.size() > 0) void'(src1_q.pop_front());
      drive();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", DW'(exp_q.size()), '0);
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      #1;
      check("rst_s0_ready", DW'(s0_ready), '0);
      check("rst_s1_ready", DW'(s1_ready), '0);
      check("rst_wr_en", DW'(fifo_wr_en), '0);
      check("rst_din", fifo_din, '0);
`ifdef ARB_PKT_CNT_EN
      check("rst_cnt0", DW'(pkt_cnt0), '0);
      check("rst_cnt1", DW'(pkt_cnt1), '0);
`endif
      fifo_full = 1'b0;
      fifo_rdy  = 1'b0;
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      drive();
      w0 = 0; w1 = 0; run = 0; max_run = 0;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
   endtask

   // Entry from WAIT_RDY: two idle samples then the first write
   task automatic check_entry_latency(input string tag);
      tick(); check({tag, "_lat0"}, DW'(wr_s), '0);
      tick(); check({tag, "_lat1"}, DW'(wr_s), '0);
      tick(); check({tag, "_lat2"}, DW'(wr_s), DW'(1));
   endtask

   initial begin
      int n;
      nrst = 1'b0; fifo_full = 1'b0; fifo_rdy = 1'b0;
      drive();
      @(posedge clk);

      // Startup: held in WAIT_RDY while fifo_rdy is low
      do_reset();
      add_pkt(0, 1, 2);
      drive();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("startup_no_wr", DW'(wr_s), '0);
      end
      fifo_rdy = 1'b1;
      check_entry_latency("startup");
      drain(20);

      // Tie from IDLE: s0 first, then s1 back-to-back
      do_reset();
      fifo_rdy = 1'b1;
      add_pkt(0, 1, 4);
      add_pkt(1, 1, 4);
      drive();
      drain(30);
      check("tie_run", DW'(max_run), DW'(8));
`ifdef ARB_PKT_CNT_EN
      check("tie_cnt0", DW'(pkt_cnt0), DW'(1));
      check("tie_cnt1", DW'(pkt_cnt1), DW'(1));
`endif

      // Backpressure on beat 2 of an s1 packet, then a fifo_rdy dip
      do_reset();
      fifo_rdy = 1'b1;
      add_pkt(1, 2, 4);
      drive();
      n = 0;
      while (exp_q.size() > 3 && n < 10) begin
         tick();
         n++;
      end
      check("bp_first_write", DW'(exp_q.size()), DW'(3));
      fifo_full = 1'b1;
      add_pkt(0, 2, 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_full_no_wr", DW'(wr_s), '0);
         check("bp_full_rdy1", DW'(rdy1_s), '0);
         check("bp_full_rdy0", DW'(rdy0_s), '0);
      end
      fifo_full = 1'b0;
      fifo_rdy  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bp_rdy_low_no_wr", DW'(wr_s), '0);
      end
      fifo_rdy = 1'b1;
      tick();
      check("bp_resume_wr", DW'(wr_s), DW'(1));
      check("bp_resume_rdy1", DW'(rdy1_s), DW'(1));
      drain(30);

      // Fairness with single-beat packets
      do_reset();
      fifo_rdy = 1'b1;
      for (int i = 0; i < 50; i++) begin
         add_pkt(0, i, 1);
         add_pkt(1, i, 1);
      end
      drive();
      drain(200);
      check("fair_w0", DW'(w0), DW'(50));
      check("fair_w1", DW'(w1), DW'(50));
      check("fair_run", DW'(max_run), DW'(100));
`ifdef ARB_PKT_CNT_EN
      check("fair_cnt0", DW'(pkt_cnt0), DW'(50));
      check("fair_cnt1", DW'(pkt_cnt1), DW'(50));
`endif

      // Reset in the middle of a 5-beat s0 packet
      do_reset();
      fifo_rdy = 1'b1;
      add_pkt(0, 3, 1);
      drive();
      drain(20);
`ifdef ARB_PKT_CNT_EN
      check("mid_cnt0_before", DW'(pkt_cnt0), DW'(1));
`endif
      add_pkt(0, 4, 5);
      drive();
      n = 0;
      while (exp_q.size() > 3 && n < 20) begin
         tick();
         n++;
      end
      check("mid_two_beats", DW'(exp_q.size()), DW'(3));
      do_reset();
      fifo_rdy = 1'b1;
      add_pkt(0, 5, 1);
      drive();
      check_entry_latency("mid_reentry");
      drain(20);

`ifdef ARB_PKT_CNT_EN
      // Counter wrap
      do_reset();
      fifo_rdy = 1'b1;
      force dut.pkt_cnt0_r = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 release dut.pkt_cnt0_r;
      check("wrap_preset", DW'(pkt_cnt0), DW'(32'hFFFF_FFFF));
      add_pkt(0, 6, 2);
      drive();
      drain(20);
      tick();
      check("wrap_cnt0", DW'(pkt_cnt0), '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
